// File: rtl/change_return_sequencer.sv
// rtl/change_return_sequencer.sv - greedy coin-return FSM with hopper handshake and debit pulses
// Optional inactivity timeout start is enabled by defining CHANGE_TIMEOUT_EN.
module change_return_sequencer #(
    parameter int TOTAL_BITS  = 31,
    parameter int COIN0_VALUE = 100,
    parameter int COIN1_VALUE = 500,
    parameter int COIN2_VALUE = 1000,
    parameter int WAIT_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_trigger_return,
    input  logic                  i_activity,
    input  logic [TOTAL_BITS-1:0] i_balance,
    input  logic                  i_dispense_ack,
    output logic                  o_dispense_req,
    output logic [2:0]            o_dispense_coin,
    output logic                  o_debit_valid,
    output logic [TOTAL_BITS-1:0] o_debit,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [31:0]           o_wait_time
);

    localparam logic [TOTAL_BITS-1:0] C0 = TOTAL_BITS'(COIN0_VALUE);
    localparam logic [TOTAL_BITS-1:0] C1 = TOTAL_BITS'(COIN1_VALUE);
    localparam logic [TOTAL_BITS-1:0] C2 = TOTAL_BITS'(COIN2_VALUE);
    localparam logic [31:0]           WAIT_RELOAD = 32'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_DISPENSE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [TOTAL_BITS-1:0] rem_q, rem_d;
    logic                  req_q, req_d;
    logic [2:0]            coin_q, coin_d;
    logic                  debit_valid_q, debit_valid_d;
    logic [TOTAL_BITS-1:0] debit_q, debit_d;
    logic                  done_q, done_d;
    logic [TOTAL_BITS-1:0] coin_value;
    logic                  timeout;
    logic                  start;

    assign start = (state_q == S_IDLE) && (i_trigger_return || timeout);

`ifdef CHANGE_TIMEOUT_EN
    logic [31:0] wait_q, wait_d;

    assign timeout = (wait_q == 32'd0) && (i_balance >= C0);

    // Counter only moves in IDLE; a starting cycle leaves it alone (trigger wins over activity).
    always_comb begin
        wait_d = wait_q;
        if (state_q == S_DONE) begin
            wait_d = WAIT_RELOAD;
        end else if (state_q == S_IDLE && !start) begin
            if (i_activity) begin
                wait_d = WAIT_RELOAD;
            end else if (wait_q != 32'd0) begin
                wait_d = wait_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= WAIT_RELOAD;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign o_wait_time = wait_q;
`else
    logic unused_activity;

    assign unused_activity = i_activity;
    assign timeout         = 1'b0;
    assign o_wait_time     = WAIT_RELOAD;
`endif

    always_comb begin
        coin_value = '0;
        case (coin_q)
            3'b100:  coin_value = C2;
            3'b010:  coin_value = C1;
            3'b001:  coin_value = C0;
            default: coin_value = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        req_d         = req_q;
        coin_d        = coin_q;
        debit_valid_d = 1'b0;
        debit_d       = '0;
        done_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = i_balance;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (rem_q >= C2) begin
                    coin_d  = 3'b100;
                    req_d   = 1'b1;
                    state_d = S_DISPENSE;
                end else if (rem_q >= C1) begin
                    coin_d  = 3'b010;
                    req_d   = 1'b1;
                    state_d = S_DISPENSE;
                end else if (rem_q >= C0) begin
                    coin_d  = 3'b001;
                    req_d   = 1'b1;
                    state_d = S_DISPENSE;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DISPENSE: begin
                if (i_dispense_ack && req_q) begin
                    req_d         = 1'b0;
                    coin_d        = 3'b000;
                    rem_d         = rem_q - coin_value;
                    debit_valid_d = 1'b1;
                    debit_d       = coin_value;
                    state_d       = S_SELECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rem_q         <= '0;
            req_q         <= 1'b0;
            coin_q        <= 3'b000;
            debit_valid_q <= 1'b0;
            debit_q       <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            req_q         <= req_d;
            coin_q        <= coin_d;
            debit_valid_q <= debit_valid_d;
            debit_q       <= debit_d;
            done_q        <= done_d;
        end
    end

    assign o_dispense_req  = req_q;
    assign o_dispense_coin = coin_q;
    assign o_debit_valid   = debit_valid_q;
    assign o_debit         = debit_q;
    assign o_done          = done_q;
    assign o_busy          = (state_q != S_IDLE);

endmodule
